// File: rtl/parity_frame_checker_pkg.sv
// Shared definitions for the XOR-parity serial link (receive checker and transmit generator).
package parity_frame_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Pass when data-XOR, received parity bit and mode constant cancel out.
  function automatic logic parity_ok(input logic i_acc, input logic i_par_bit, input logic i_mode);
    return ~(i_acc ^ i_par_bit ^ i_mode);
  endfunction

endpackage

// File: rtl/parity_frame_checker_serial_parity_acc.sv
// Shift register plus running XOR for one frame; i_start seeds a fresh frame with its first bit.
module serial_parity_acc #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_shift,
  input  logic              i_bit,
  output logic [DATA_W-1:0] o_data,
  output logic              o_par
);

  logic [DATA_W-1:0] r_data;
  logic              r_par;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_seed;

  // LSB-first seeds at the top and shifts down, so bit 0 ends in o_data[0] after DATA_W beats.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_shifted = {r_data[DATA_W-2:0], i_bit};
      assign w_seed    = {{(DATA_W-1){1'b0}}, i_bit};
    end else begin : g_lsb
      assign w_shifted = {i_bit, r_data[DATA_W-1:1]};
      assign w_seed    = {i_bit, {(DATA_W-1){1'b0}}};
    end
  endgenerate

  // Frame accumulator: start discards any partial frame.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_data <= {DATA_W{1'b0}};
      r_par  <= 1'b0;
    end else if (i_start) begin
      r_data <= w_seed;
      r_par  <= i_bit;
    end else if (i_shift) begin
      r_data <= w_shifted;
      r_par  <= r_par ^ i_bit;
    end
  end

  assign o_data = r_data;
  assign o_par  = r_par;

endmodule

// File: rtl/parity_frame_checker.sv
// Receive-side frame deserialiser and parity checker with a one-entry valid/ready result register.
module parity_frame_checker
  import parity_frame_checker_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ODD_PAR   = 0,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] data_out,
  output logic              par_ok,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              abort,
  output logic              overrun
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             PAR_MODE = (ODD_PAR != 32'd0) ? PAR_ODD : PAR_EVEN;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_start;
  logic              w_shift;
  logic              w_abort;
  logic              w_done;
  logic [DATA_W-1:0] w_acc_data;
  logic              w_acc_par;
  logic              w_par_ok;
  logic [DATA_W-1:0] r_data_out;
  logic              r_par_ok;
  logic              r_out_valid;
  logic              r_abort;
  logic              r_overrun;

  serial_parity_acc #(
    .DATA_W   (DATA_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_acc (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_start(w_start),
    .i_shift(w_shift),
    .i_bit  (bit_in),
    .o_data (w_acc_data),
    .o_par  (w_acc_par)
  );

  // State and bit-index registers; r_cnt holds the index of the next expected data bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state decode; a sof beat always starts a new frame, aborting any partial one.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_abort     = 1'b0;
    w_done      = 1'b0;
    if (bit_valid && sof) begin
      w_start     = 1'b1;
      w_abort     = (r_state != ST_IDLE);
      w_state_nxt = ST_DATA;
      w_cnt_nxt   = CNT_ONE;
    end else if (bit_valid) begin
      case (r_state)
        ST_DATA: begin
          w_shift = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_PARITY;
            w_cnt_nxt   = {CNT_W{1'b0}};
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        ST_PARITY: begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  assign w_par_ok = parity_ok(w_acc_par, bit_in, PAR_MODE);

  // Result register: load when empty or draining this cycle, otherwise drop and flag overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data_out  <= {DATA_W{1'b0}};
      r_par_ok    <= 1'b0;
      r_out_valid <= 1'b0;
      r_abort     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_abort   <= w_abort;
      r_overrun <= 1'b0;
      if (w_done && (!r_out_valid || out_ready)) begin
        r_data_out  <= w_acc_data;
        r_par_ok    <= w_par_ok;
        r_out_valid <= 1'b1;
      end else if (w_done) begin
        r_overrun <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign data_out  = r_data_out;
  assign par_ok    = r_par_ok;
  assign out_valid = r_out_valid;
  assign abort     = r_abort;
  assign overrun   = r_overrun;

endmodule
